// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch/prefetch unit.
// Issues ROM reads from a private fetch address whenever a FIFO slot is still
// free after counting the read already in flight. Each ROM result is parked in a
// small prefetch FIFO together with its address, and the FIFO head goes to the
// core over a valid/ready handshake. A jump empties the FIFO, drops the read in
// flight and restarts fetching at the jump target.
module instr_fetch #(
  parameter int DEPTH = 4,
  parameter int AW    = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  output logic          rom_en,
  output logic [AW-1:0] rom_addr,
  input  logic [15:0]   rom_data,
  input  logic          jump,
  input  logic [AW-1:0] jump_addr,
  output logic [15:0]   instr,
  output logic [AW-1:0] instr_pc,
  output logic          instr_valid,
  input  logic          instr_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);
  localparam logic [AW-1:0] ADDR_ONE = AW'(1'b1);

  // Architectural state
  logic [AW-1:0] fetch_addr_q, fetch_addr_d;
  logic          inflight_q,   inflight_d;
  logic [AW-1:0] tag_q,        tag_d;
  logic [PW-1:0] wptr_q,       wptr_d;
  logic [PW-1:0] rptr_q,       rptr_d;
  logic [CW-1:0] count_q,      count_d;

  // Prefetch storage: instruction word and the address it came from
  logic [15:0]   fifo_instr_q [DEPTH];
  logic [AW-1:0] fifo_pc_q    [DEPTH];

  // Per-cycle events
  logic [CW-1:0] used_s;
  logic          credit_s;
  logic          issue_s;
  logic          push_s;
  logic          pop_s;

  // Slots already spoken for: buffered entries plus the read still coming back.
  assign used_s   = count_q + (inflight_q ? CNT_ONE : {CW{1'b0}});
  assign credit_s = (used_s < DEPTH_C);

  // The strobe depends on registered state only; reset_n forces it low while held.
  assign rom_en   = reset_n & credit_s;
  assign rom_addr = fetch_addr_q;

  // A jump cancels every issue, return and pop at its edge.
  assign issue_s  = credit_s & ~jump;
  assign push_s   = inflight_q & ~jump;

  assign instr_valid = (count_q != {CW{1'b0}});
  assign pop_s       = instr_valid & instr_ready & ~jump;

  // Head is presented as zero when empty, which also keeps it zero under reset.
  assign instr    = instr_valid ? fifo_instr_q[rptr_q] : 16'h0000;
  assign instr_pc = instr_valid ? fifo_pc_q[rptr_q]    : {AW{1'b0}};

  // Next-state logic for fetch address, in-flight tracking and FIFO bookkeeping.
  always_comb begin
    fetch_addr_d = fetch_addr_q;
    inflight_d   = inflight_q;
    tag_d        = tag_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;
    if (jump) begin
      fetch_addr_d = jump_addr;
      inflight_d   = 1'b0;
      wptr_d       = {PW{1'b0}};
      rptr_d       = {PW{1'b0}};
      count_d      = {CW{1'b0}};
    end else begin
      if (issue_s) begin
        inflight_d   = 1'b1;
        tag_d        = fetch_addr_q;
        fetch_addr_d = fetch_addr_q + ADDR_ONE;
      end else begin
        inflight_d   = 1'b0;
      end
      if (push_s) begin
        wptr_d = wptr_q + PTR_ONE;
      end else begin
        wptr_d = wptr_q;
      end
      if (pop_s) begin
        rptr_d = rptr_q + PTR_ONE;
      end else begin
        rptr_d = rptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_addr_q <= {AW{1'b0}};
      inflight_q   <= 1'b0;
      tag_q        <= {AW{1'b0}};
      wptr_q       <= {PW{1'b0}};
      rptr_q       <= {PW{1'b0}};
      count_q      <= {CW{1'b0}};
    end else begin
      fetch_addr_q <= fetch_addr_d;
      inflight_q   <= inflight_d;
      tag_q        <= tag_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
    end
  end

  // FIFO storage: capture the returning ROM word with its address tag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_instr_q[i] <= 16'h0000;
        fifo_pc_q[i]    <= {AW{1'b0}};
      end
    end else if (push_s) begin
      fifo_instr_q[wptr_q] <= rom_data;
      fifo_pc_q[wptr_q]    <= tag_q;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios with fixed expected
// pc/instr sequences, then randomized ready/jump/reset traffic compared against
// a queue-based model of the prefetch behaviour.
module tb_instr_fetch;

  localparam int DEPTH = 4;
  localparam int AW    = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          rom_en;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_data = 16'h0000;
  logic          jump = 1'b0;
  logic [AW-1:0] jump_addr = 16'h0000;
  logic [15:0]   instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_ready = 1'b0;

  int checks = 0;
  int passes = 0;

  instr_fetch #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .jump(jump), .jump_addr(jump_addr),
    .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  // ROM contents: word at address a is 0x1000 + a
  function automatic logic [15:0] rom_fn(input logic [15:0] a);
    return a + 16'h1000;
  endfunction

  // Registered ROM port, one cycle of latency
  always @(posedge clk) begin
    if (rom_en) rom_data <= rom_fn(rom_addr);
  end

  // Reference model: a queue of buffered {pc, instr}, one pending read, fetch address
  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] ins;
  } entry_t;
  entry_t      mq[$];
  int          m_inflight;
  logic [15:0] m_tag;
  logic [15:0] m_fetch;

  task automatic model_clear();
    mq.delete();
    m_inflight = 0;
    m_tag      = 16'h0000;
    m_fetch    = 16'h0000;
  endtask

  // Advance one clock edge, update the model from the inputs seen at that edge
  task automatic tick();
    int     en;
    entry_t e;
    @(posedge clk);
    if (!reset_n) begin
      model_clear();
    end else begin
      en = ((mq.size() + m_inflight) < DEPTH) ? 1 : 0;
      if (jump) begin
        mq.delete();
        m_inflight = 0;
        m_fetch    = jump_addr;
      end else begin
        if (mq.size() != 0 && instr_ready) mq.delete(0);
        if (m_inflight != 0) begin
          e.pc  = m_tag;
          e.ins = rom_fn(m_tag);
          mq.push_back(e);
        end
        if (en != 0) begin
          m_inflight = 1;
          m_tag      = m_fetch;
          m_fetch    = m_fetch + 16'h0001;
        end else begin
          m_inflight = 0;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    jump        = 1'b0;
    instr_ready = 1'b0;
    model_clear();
    repeat (2) tick();
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({rom_en, instr_valid} !== 2'b00) $display("FAIL reset_strobes: got en/valid=%b want 00", {rom_en, instr_valid});
    else passes++;
    checks++;
    if ({rom_addr, instr, instr_pc} !== 48'h0) $display("FAIL reset_data: got addr=%h instr=%h pc=%h want all 0", rom_addr, instr, instr_pc);
    else passes++;
    tick();
    checks++;
    if ({rom_en, instr_valid, rom_addr} !== 18'h0) $display("FAIL reset_held: got en=%b valid=%b addr=%h want 0", rom_en, instr_valid, rom_addr);
    else passes++;
  endtask

  task automatic test_stream();
    logic [15:0] p;
    do_reset();
    instr_ready = 1'b1;
    checks++;
    if ({rom_en, rom_addr} !== {1'b1, 16'h0000}) $display("FAIL stream_first_read: got en=%b addr=%h want 1 0000", rom_en, rom_addr);
    else passes++;
    tick();
    checks++;
    if (instr_valid !== 1'b0) $display("FAIL stream_latency: got valid=%b after 1st edge want 0", instr_valid);
    else passes++;
    for (int i = 0; i < 100; i++) begin
      tick();
      p = 16'(i);
      checks++;
      if ({instr_valid, instr_pc, instr} !== {1'b1, p, rom_fn(p)})
        $display("FAIL stream_seq[%0d]: got v=%b pc=%h ins=%h want 1 %h %h", i, instr_valid, instr_pc, instr, p, rom_fn(p));
      else passes++;
    end
  endtask

  task automatic test_backpressure();
    int en_cnt;
    int bad_addr;
    logic [15:0] p;
    do_reset();
    en_cnt   = 0;
    bad_addr = 0;
    for (int c = 0; c < 10; c++) begin
      if (rom_en) begin
        if (rom_addr !== 16'(en_cnt)) bad_addr++;
        en_cnt++;
      end
      tick();
    end
    checks++;
    if (en_cnt != DEPTH) $display("FAIL bp_issue_count: got %0d want %0d", en_cnt, DEPTH);
    else passes++;
    checks++;
    if (bad_addr != 0) $display("FAIL bp_issue_addrs: got %0d wrong addresses want 0", bad_addr);
    else passes++;
    checks++;
    if ({rom_en, instr_valid, instr_pc, instr} !== {1'b0, 1'b1, 16'h0000, 16'h1000})
      $display("FAIL bp_full_head: got en=%b v=%b pc=%h ins=%h want 0 1 0000 1000", rom_en, instr_valid, instr_pc, instr);
    else passes++;
    checks++;
    if ({dut.count_q, dut.inflight_q} !== {3'd4, 1'b0}) $display("FAIL bp_settle: got count=%0d inflight=%b want 4 0", dut.count_q, dut.inflight_q);
    else passes++;
    instr_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      p = 16'(i);
      checks++;
      if ({instr_valid, instr_pc, instr} !== {1'b1, p, rom_fn(p)})
        $display("FAIL bp_drain[%0d]: got v=%b pc=%h ins=%h want 1 %h %h", i, instr_valid, instr_pc, instr, p, rom_fn(p));
      else passes++;
      tick();
      if (i == 0) begin
        checks++;
        if (rom_en !== 1'b1) $display("FAIL bp_credit_return: got en=%b want 1", rom_en);
        else passes++;
      end
    end
    // Refill, then pull reset mid-cycle with the FIFO full
    instr_ready = 1'b0;
    repeat (8) tick();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({rom_en, instr_valid, rom_addr, instr, instr_pc} !== 50'h0)
      $display("FAIL reset_when_full: got en=%b v=%b addr=%h ins=%h pc=%h want all 0", rom_en, instr_valid, rom_addr, instr, instr_pc);
    else passes++;
  endtask

  task automatic test_jump_inflight();
    logic [15:0] p;
    do_reset();
    instr_ready = 1'b1;
    repeat (7) tick();
    checks++;
    if ({instr_valid, instr_pc} !== {1'b1, 16'h0005}) $display("FAIL jmp_pre_head: got v=%b pc=%h want 1 0005", instr_valid, instr_pc);
    else passes++;
    jump = 1'b1;
    jump_addr = 16'h0200;
    tick();
    jump = 1'b0;
    checks++;
    if ({instr_valid, rom_en, rom_addr} !== {1'b0, 1'b1, 16'h0200}) $display("FAIL jmp_redirect: got v=%b en=%b addr=%h want 0 1 0200", instr_valid, rom_en, rom_addr);
    else passes++;
    tick();
    checks++;
    if (instr_valid !== 1'b0) $display("FAIL jmp_drop_inflight: got v=%b pc=%h want valid 0", instr_valid, instr_pc);
    else passes++;
    for (int i = 0; i < 6; i++) begin
      tick();
      p = 16'h0200 + 16'(i);
      checks++;
      if ({instr_valid, instr_pc, instr} !== {1'b1, p, rom_fn(p)})
        $display("FAIL jmp_stream[%0d]: got v=%b pc=%h ins=%h want 1 %h %h", i, instr_valid, instr_pc, instr, p, rom_fn(p));
      else passes++;
    end
  endtask

  task automatic test_jump_full();
    do_reset();
    repeat (8) tick();
    jump = 1'b1;
    jump_addr = 16'h0300;
    instr_ready = 1'b1;
    tick();
    jump = 1'b0;
    checks++;
    if ({instr_valid, rom_en, rom_addr} !== {1'b0, 1'b1, 16'h0300}) $display("FAIL jmpfull_flush: got v=%b en=%b addr=%h want 0 1 0300", instr_valid, rom_en, rom_addr);
    else passes++;
    repeat (2) tick();
    checks++;
    if ({instr_valid, instr_pc, instr} !== {1'b1, 16'h0300, 16'h1300}) $display("FAIL jmpfull_first: got v=%b pc=%h ins=%h want 1 0300 1300", instr_valid, instr_pc, instr);
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] p;
    do_reset();
    instr_ready = 1'b1;
    repeat (5) tick();
    jump = 1'b1;
    jump_addr = 16'h0010;
    tick();
    jump_addr = 16'h0020;
    tick();
    jump = 1'b0;
    checks++;
    if ({instr_valid, rom_en, rom_addr} !== {1'b0, 1'b1, 16'h0020}) $display("FAIL b2b_redirect: got v=%b en=%b addr=%h want 0 1 0020", instr_valid, rom_en, rom_addr);
    else passes++;
    tick();
    checks++;
    if (instr_valid !== 1'b0) $display("FAIL b2b_gap: got v=%b pc=%h want valid 0", instr_valid, instr_pc);
    else passes++;
    for (int i = 0; i < 6; i++) begin
      tick();
      p = 16'h0020 + 16'(i);
      checks++;
      if ({instr_valid, instr_pc, instr} !== {1'b1, p, rom_fn(p)})
        $display("FAIL b2b_stream[%0d]: got v=%b pc=%h ins=%h want 1 %h %h", i, instr_valid, instr_pc, instr, p, rom_fn(p));
      else passes++;
    end
  endtask

  task automatic test_wrap();
    logic [15:0] p;
    do_reset();
    instr_ready = 1'b1;
    repeat (3) tick();
    jump = 1'b1;
    jump_addr = 16'hFFFE;
    tick();
    jump = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      p = 16'hFFFE + 16'(i);
      checks++;
      if ({instr_valid, instr_pc, instr} !== {1'b1, p, rom_fn(p)})
        $display("FAIL wrap[%0d]: got v=%b pc=%h ins=%h want 1 %h %h", i, instr_valid, instr_pc, instr, p, rom_fn(p));
      else passes++;
    end
  endtask

  task automatic test_random();
    logic exp_en;
    do_reset();
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if (cyc == 500) begin
        reset_n = 1'b0;
        model_clear();
        #1;
        checks++;
        if ({rom_en, instr_valid, rom_addr, instr, instr_pc} !== 50'h0)
          $display("FAIL rnd_reset_outputs: got en=%b v=%b addr=%h ins=%h pc=%h want all 0", rom_en, instr_valid, rom_addr, instr, instr_pc);
        else passes++;
      end
      if (cyc == 502) begin
        reset_n = 1'b1;
        #1;
      end
      exp_en = reset_n && ((mq.size() + m_inflight) < DEPTH);
      checks++;
      if (rom_en !== exp_en) $display("FAIL rnd_rom_en@%0d: got %b want %b", cyc, rom_en, exp_en);
      else passes++;
      checks++;
      if (rom_addr !== m_fetch) $display("FAIL rnd_rom_addr@%0d: got %h want %h", cyc, rom_addr, m_fetch);
      else passes++;
      checks++;
      if (instr_valid !== (mq.size() != 0)) $display("FAIL rnd_valid@%0d: got %b want %b", cyc, instr_valid, (mq.size() != 0));
      else passes++;
      if (mq.size() != 0) begin
        checks++;
        if ({instr_pc, instr} !== {mq[0].pc, mq[0].ins})
          $display("FAIL rnd_head@%0d: got pc=%h ins=%h want %h %h", cyc, instr_pc, instr, mq[0].pc, mq[0].ins);
        else passes++;
      end
      checks++;
      if (int'(dut.count_q) + int'(dut.inflight_q) > DEPTH)
        $display("FAIL rnd_credit@%0d: got count+inflight=%0d want <= %0d", cyc, int'(dut.count_q) + int'(dut.inflight_q), DEPTH);
      else passes++;
      instr_ready = ($urandom_range(0, 3) != 0);
      jump        = ($urandom_range(0, 24) == 0);
      jump_addr   = 16'($urandom);
      tick();
    end
    jump = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_jump_inflight();
    test_jump_full();
    test_back_to_back();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
